// File: rtl/jtag_dr_bank.sv
// JTAG data-register bank: IDCODE/BYPASS plus ADDR, DATA_WR, DATA_RD and CTRL DRs
// that drive a single-outstanding bus transaction engine.
package jtag_pkg;
  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'd0,
    RUN_TEST_IDLE    = 4'd1,
    SELECT_DR_SCAN   = 4'd2,
    CAPTURE_DR       = 4'd3,
    SHIFT_DR         = 4'd4,
    EXIT1_DR         = 4'd5,
    PAUSE_DR         = 4'd6,
    EXIT2_DR         = 4'd7,
    UPDATE_DR        = 4'd8,
    SELECT_IR_SCAN   = 4'd9,
    CAPTURE_IR       = 4'd10,
    SHIFT_IR         = 4'd11,
    EXIT1_IR         = 4'd12,
    PAUSE_IR         = 4'd13,
    EXIT2_IR         = 4'd14,
    UPDATE_IR        = 4'd15
  } tap_ctrl_fsm_t;

  typedef enum logic [2:0] {
    BYPASS           = 3'd0,
    IDCODE           = 3'd1,
    ADDR_REGISTER    = 3'd2,
    DATA_WR_REGISTER = 3'd3,
    DATA_RD_REGISTER = 3'd4,
    CTRL_REGISTER    = 3'd5
  } ir_decoding_t;
endpackage

module jtag_dr_bank
  import jtag_pkg::*;
#(
  parameter logic [31:0] IDCODE_VAL = 32'h10F,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  tck,
  input  logic                  trstn,
  input  logic                  tdi,
  output logic                  tdo,
  input  tap_ctrl_fsm_t         tap_state,
  input  ir_decoding_t          ir_dec,
  output logic                  txn_valid,
  input  logic                  txn_ready,
  output logic                  txn_write,
  output logic [ADDR_WIDTH-1:0] txn_addr,
  output logic [DATA_WIDTH-1:0] txn_wdata,
  output logic [2:0]            txn_size,
  input  logic                  resp_valid,
  input  logic [DATA_WIDTH-1:0] resp_rdata,
  input  logic [1:0]            resp_err
);

  localparam int unsigned AD_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned SR_W   = (AD_MAX > 32) ? AD_MAX : 32;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t                state_q, state_n;
  logic [SR_W-1:0]       sr_q, sr_cap, sr_shift, sr_up;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic                  done_q, ovf_q, inc_q;
  logic [1:0]            err_q;
  logic [7:0]            status;
  int unsigned           dr_len;
  logic                  dr_valid;
  logic                  busy, upd_addr, upd_wdata, upd_ctrl;
  logic                  start_cmd, clr_cmd, resp_evt, ovf_evt;

  assign busy      = (state_q != S_IDLE);
  assign status    = {3'b000, ovf_q, err_q, done_q, busy};
  assign txn_addr  = addr_q;
  assign txn_wdata = wdata_q;

  // Active DR selection: length and capture value
  always_comb begin
    dr_len   = 1;
    dr_valid = 1'b1;
    sr_cap   = '0;
    case (ir_dec)
      BYPASS:           begin dr_len = 1;          sr_cap = '0;                end
      IDCODE:           begin dr_len = 32;         sr_cap = SR_W'(IDCODE_VAL); end
      ADDR_REGISTER:    begin dr_len = ADDR_WIDTH; sr_cap = SR_W'(addr_q);     end
      DATA_WR_REGISTER: begin dr_len = DATA_WIDTH; sr_cap = SR_W'(wdata_q);    end
      DATA_RD_REGISTER: begin dr_len = DATA_WIDTH; sr_cap = SR_W'(rdata_q);    end
      CTRL_REGISTER:    begin dr_len = 8;          sr_cap = SR_W'(status);     end
      default:          dr_valid = 1'b0;
    endcase
  end

  // Shift right with tdi entering at bit L-1; bits above the DR stay zero
  always_comb begin
    sr_up    = {1'b0, sr_q[SR_W-1:1]};
    sr_shift = '0;
    for (int unsigned i = 0; i < SR_W; i++) begin
      if (i == dr_len - 1)
        sr_shift[i] = tdi;
      else if (i < dr_len - 1)
        sr_shift[i] = sr_up[i];
      else
        sr_shift[i] = 1'b0;
    end
  end

  always_comb begin
    tdo       = (tap_state == SHIFT_DR && dr_valid) ? sr_q[0] : 1'b0;
    upd_addr  = (tap_state == UPDATE_DR) && (ir_dec == ADDR_REGISTER);
    upd_wdata = (tap_state == UPDATE_DR) && (ir_dec == DATA_WR_REGISTER);
    upd_ctrl  = (tap_state == UPDATE_DR) && (ir_dec == CTRL_REGISTER);
    start_cmd = upd_ctrl && sr_q[0];
    clr_cmd   = upd_ctrl && sr_q[6];
    resp_evt  = (state_q == S_WAIT) && resp_valid;
    ovf_evt   = busy && (start_cmd || upd_addr || upd_wdata);
  end

  // Transaction FSM next state
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:  if (start_cmd)  state_n = S_REQ;
      S_REQ:   if (txn_ready)  state_n = S_WAIT;
      S_WAIT:  if (resp_valid) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge tck) begin
    if (!trstn) begin
      state_q   <= S_IDLE;
      txn_valid <= 1'b0;
      txn_write <= 1'b0;
      txn_size  <= 3'd0;
      inc_q     <= 1'b0;
      sr_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 2'd0;
    end else begin
      state_q   <= state_n;
      txn_valid <= (state_n == S_REQ);

      if (tap_state == CAPTURE_DR && dr_valid)
        sr_q <= sr_cap;
      else if (tap_state == SHIFT_DR && dr_valid)
        sr_q <= sr_shift;

      // Host writes are locked out while a transaction is in flight
      if (upd_addr && !busy)
        addr_q <= sr_q[ADDR_WIDTH-1:0];
      else if (resp_evt && inc_q)
        addr_q <= addr_q + (ADDR_WIDTH'(1) << txn_size);

      if (upd_wdata && !busy)
        wdata_q <= sr_q[DATA_WIDTH-1:0];

      if (start_cmd && !busy) begin
        txn_write <= sr_q[1];
        inc_q     <= sr_q[2];
        txn_size  <= sr_q[5:3];
      end

      if (resp_evt) begin
        err_q <= resp_err;
        if (!txn_write)
          rdata_q <= resp_rdata;
      end

      // Sticky set events take priority over a coincident clear
      if (resp_evt)
        done_q <= 1'b1;
      else if (clr_cmd)
        done_q <= 1'b0;

      if (ovf_evt)
        ovf_q <= 1'b1;
      else if (clr_cmd)
        ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_dr_bank.sv
// Directed bench for jtag_dr_bank: DR scans, bus transactions, sticky flags, reset abort.
module tb_jtag_dr_bank;
  import jtag_pkg::*;

  logic          tck = 1'b0;
  logic          trstn, tdi, tdo;
  tap_ctrl_fsm_t tap_state;
  ir_decoding_t  ir_dec;
  logic          txn_valid, txn_ready, txn_write;
  logic [31:0]   txn_addr, txn_wdata, resp_rdata;
  logic [2:0]    txn_size;
  logic          resp_valid;
  logic [1:0]    resp_err;

  int checks = 0;
  int errors = 0;
  logic [63:0] d;

  jtag_dr_bank dut (
    .tck(tck), .trstn(trstn), .tdi(tdi), .tdo(tdo),
    .tap_state(tap_state), .ir_dec(ir_dec),
    .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_write(txn_write),
    .txn_addr(txn_addr), .txn_wdata(txn_wdata), .txn_size(txn_size),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 tck = ~tck;

  task automatic cyc();
    @(posedge tck);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Capture, shift n bits of din LSB first collecting tdo, then update
  task automatic scan(input ir_decoding_t ir, input int unsigned n, input logic [63:0] din,
                      input logic resp_at_upd, output logic [63:0] dout);
    dout = '0;
    ir_dec = ir;
    tap_state = CAPTURE_DR;
    cyc();
    for (int unsigned i = 0; i < n; i++) begin
      tap_state = SHIFT_DR;
      tdi = din[i];
      #1;
      dout[i] = tdo;
      cyc();
    end
    tdi = 1'b0;
    tap_state = UPDATE_DR;
    if (resp_at_upd) resp_valid = 1'b1;
    cyc();
    resp_valid = 1'b0;
    tap_state = RUN_TEST_IDLE;
  endtask

  initial begin
    trstn = 1'b0; tdi = 1'b0; tap_state = TEST_LOGIC_RESET; ir_dec = BYPASS;
    txn_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0; resp_err = 2'd0;
    cyc(); cyc();
    check("rst_txn_valid", 64'(txn_valid), 64'd0);
    check("rst_txn_write", 64'(txn_write), 64'd0);
    check("rst_txn_size",  64'(txn_size),  64'd0);
    check("rst_txn_addr",  64'(txn_addr),  64'd0);
    trstn = 1'b1;
    tap_state = RUN_TEST_IDLE;
    cyc();

    scan(IDCODE, 32, 64'd0, 1'b0, d);
    check("idcode", d, 64'h0000_010F);

    scan(BYPASS, 3, 64'b101, 1'b0, d);
    check("bypass", d, 64'b010);

    scan(ir_decoding_t'(3'd6), 4, 64'hF, 1'b0, d);
    check("undef_ir_tdo", d, 64'd0);

    // Write transaction with back-pressure
    scan(ADDR_REGISTER, 32, 64'h1000, 1'b0, d);
    scan(DATA_WR_REGISTER, 32, 64'hDEAD_BEEF, 1'b0, d);
    scan(CTRL_REGISTER, 8, 64'h03, 1'b0, d);
    check("wr_status_pre", d, 64'h00);
    check("wr_valid_first", 64'(txn_valid), 64'd1);
    check("wr_write", 64'(txn_write), 64'd1);
    check("wr_size", 64'(txn_size), 64'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("wr_valid_hold", 64'(txn_valid), 64'd1);
      check("wr_addr_hold", 64'(txn_addr), 64'h1000);
      check("wr_wdata_hold", 64'(txn_wdata), 64'hDEAD_BEEF);
    end
    txn_ready = 1'b1;
    cyc();
    txn_ready = 1'b0;
    check("wr_valid_drop", 64'(txn_valid), 64'd0);
    resp_valid = 1'b1; resp_err = 2'd0;
    cyc();
    resp_valid = 1'b0;
    scan(CTRL_REGISTER, 8, 64'h00, 1'b0, d);
    check("wr_status_done", d, 64'h02);

    // Read with auto-increment size 2 wrapping the address
    scan(ADDR_REGISTER, 32, 64'hFFFF_FFFC, 1'b0, d);
    scan(CTRL_REGISTER, 8, 64'h15, 1'b0, d);
    check("rd_status_pre", d, 64'h02);
    check("rd_valid", 64'(txn_valid), 64'd1);
    check("rd_write", 64'(txn_write), 64'd0);
    check("rd_size", 64'(txn_size), 64'd2);
    check("rd_addr", 64'(txn_addr), 64'hFFFF_FFFC);
    txn_ready = 1'b1;
    cyc();
    txn_ready = 1'b0;
    resp_valid = 1'b1; resp_rdata = 32'h1234_5678; resp_err = 2'd1;
    cyc();
    resp_valid = 1'b0;
    check("rd_addr_wrap", 64'(txn_addr), 64'h0);
    resp_valid = 1'b1; resp_rdata = 32'hAAAA_5555; resp_err = 2'd3;
    cyc();
    resp_valid = 1'b0;
    scan(DATA_RD_REGISTER, 32, 64'd0, 1'b0, d);
    check("rd_data", d, 64'h1234_5678);
    scan(CTRL_REGISTER, 8, 64'h00, 1'b0, d);
    check("rd_status", d, 64'h06);

    // Sticky clear, overflow on start/ADDR while busy, clear vs response race
    scan(CTRL_REGISTER, 8, 64'h40, 1'b0, d);
    scan(CTRL_REGISTER, 8, 64'h00, 1'b0, d);
    check("clr_status", d, 64'h04);
    scan(CTRL_REGISTER, 8, 64'h03, 1'b0, d);
    txn_ready = 1'b1;
    cyc();
    txn_ready = 1'b0;
    scan(CTRL_REGISTER, 8, 64'h03, 1'b0, d);
    check("wait_status", d, 64'h05);
    check("no_second_txn", 64'(txn_valid), 64'd0);
    cyc();
    check("no_second_txn2", 64'(txn_valid), 64'd0);
    scan(ADDR_REGISTER, 32, 64'h5555, 1'b0, d);
    check("addr_locked", 64'(txn_addr), 64'h0);
    scan(CTRL_REGISTER, 8, 64'h00, 1'b0, d);
    check("ovf_status", d, 64'h15);
    resp_err = 2'd0;
    scan(CTRL_REGISTER, 8, 64'h40, 1'b1, d);
    scan(CTRL_REGISTER, 8, 64'h00, 1'b0, d);
    check("clr_vs_resp", d, 64'h02);

    // Reset during REQ aborts and ignores the late response
    scan(CTRL_REGISTER, 8, 64'h01, 1'b0, d);
    check("abort_valid_pre", 64'(txn_valid), 64'd1);
    trstn = 1'b0;
    cyc();
    check("abort_valid", 64'(txn_valid), 64'd0);
    check("abort_write", 64'(txn_write), 64'd0);
    trstn = 1'b1;
    resp_valid = 1'b1; resp_rdata = 32'hCAFE_F00D; resp_err = 2'd2;
    cyc();
    resp_valid = 1'b0;
    cyc();
    scan(CTRL_REGISTER, 8, 64'h00, 1'b0, d);
    check("abort_status", d, 64'h00);
    scan(DATA_RD_REGISTER, 32, 64'd0, 1'b0, d);
    check("abort_rdata", d, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
